hll_dma_read_splitter: RTL and testbench

Upstream stage of the HyperLogLog input path. Accepts one job descriptor {length, base address} from the controller's parameter stream and turns it into a sequence of DMA read commands. Each command is size-limited and never crosses a page boundary. Tracks outstanding commands by snooping `last` on the DMA read-data stream that feeds the 512-to-320 converter, throttles issue at a credit limit, and signals job completion once all requested data has returned.

---
 rtl/hll_dma_read_splitter_if.sv | 42 ++++
 rtl/hll_dma_read_splitter.sv | 129 ++++++++++++
 tb/tb_hll_dma_read_splitter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hll_dma_read_splitter_if.sv
// Bundles the descriptor, read-command and snooped read-data streams of the
// HyperLogLog DMA read splitter; master is the splitter's view.
interface hll_dma_read_splitter_if;
   logic        s_axis_param_valid;
   logic        s_axis_param_ready;
   logic [95:0] s_axis_param_data;

   logic        m_axis_dma_read_cmd_valid;
   logic        m_axis_dma_read_cmd_ready;
   logic [63:0] m_axis_dma_read_cmd_address;
   logic [31:0] m_axis_dma_read_cmd_length;

   logic        rd_data_beat_valid;
   logic        rd_data_beat_ready;
   logic        rd_data_beat_last;

   modport master (
      input  s_axis_param_valid,
      output s_axis_param_ready,
      input  s_axis_param_data,
      output m_axis_dma_read_cmd_valid,
      input  m_axis_dma_read_cmd_ready,
      output m_axis_dma_read_cmd_address,
      output m_axis_dma_read_cmd_length,
      input  rd_data_beat_valid,
      input  rd_data_beat_ready,
      input  rd_data_beat_last
   );

   modport slave (
      output s_axis_param_valid,
      input  s_axis_param_ready,
      output s_axis_param_data,
      input  m_axis_dma_read_cmd_valid,
      output m_axis_dma_read_cmd_ready,
      input  m_axis_dma_read_cmd_address,
      input  m_axis_dma_read_cmd_length,
      output rd_data_beat_valid,
      output rd_data_beat_ready,
      output rd_data_beat_last
   );
endinterface

// File: rtl/hll_dma_read_splitter.sv
// Splits one {length, address} job into size-limited, page-safe DMA read
// commands, throttles on outstanding commands and pulses done when all data is back.
module hll_dma_read_splitter #(
   parameter int MAX_CMD_BYTES   = 4096,
   parameter int PAGE_BYTES      = 4096,
   parameter int MAX_OUTSTANDING = 8,
   parameter int BEAT_BYTES      = 64
) (
   input  logic                   user_clk,
   input  logic                   user_areset,
   hll_dma_read_splitter_if.master bus,
   output logic                   busy,
   output logic                   done,
   output logic [31:0]            cmds_issued,
   output logic [1:0]             o_dbg_state
);
   // All streams use valid/ready: a transfer happens on a rising edge where
   // both are high; the producer holds payload stable while valid && !ready.

   localparam int PAGE_W = $clog2(PAGE_BYTES);
   localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);

   if ((MAX_CMD_BYTES < BEAT_BYTES) || (PAGE_BYTES < BEAT_BYTES) ||
       (MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > 255)) begin : g_bad_cfg
      $error("hll_dma_read_splitter: invalid parameter combination");
   end

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN} state_t;

   state_t           r_state, w_state_nxt;
   logic             r_param_ready;
   logic [63:0]      r_addr;
   logic [31:0]      r_remaining;
   logic [63:0]      r_cmd_addr;
   logic [31:0]      r_cmd_len;
   logic [31:0]      r_cmds_issued;
   logic             r_busy;
   logic [CNT_W-1:0] r_outstanding, w_outstanding_nxt;

   logic             w_param_hs;
   logic             w_cmd_valid;
   logic             w_cmd_hs;
   logic             w_last_hs;
   logic             w_done;
   logic [31:0]      w_page_rem;
   logic [31:0]      w_chunk;

   assign w_param_hs  = bus.s_axis_param_valid && r_param_ready;
   assign w_cmd_valid = (r_state == S_ISSUE) && (r_outstanding < MAX_OUT_C);
   assign w_cmd_hs    = w_cmd_valid && bus.m_axis_dma_read_cmd_ready;
   assign w_last_hs   = bus.rd_data_beat_valid && bus.rd_data_beat_ready && bus.rd_data_beat_last;
   assign w_page_rem  = 32'(PAGE_BYTES) - 32'(r_addr[PAGE_W-1:0]);

   always_comb begin
      w_chunk = r_remaining;
      if (32'(MAX_CMD_BYTES) < w_chunk) w_chunk = 32'(MAX_CMD_BYTES);
      if (w_page_rem < w_chunk)         w_chunk = w_page_rem;
   end

   // A last arriving with no command in flight is spurious and is dropped.
   always_comb begin
      w_outstanding_nxt = r_outstanding;
      if (w_cmd_hs && !w_last_hs)
         w_outstanding_nxt = r_outstanding + CNT_W'(1);
      else if (!w_cmd_hs && w_last_hs && (r_outstanding != '0))
         w_outstanding_nxt = r_outstanding - CNT_W'(1);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE:  if (w_param_hs)
                     w_state_nxt = (bus.s_axis_param_data[95:64] != 32'd0) ? S_CALC : S_DRAIN;
         S_CALC:  w_state_nxt = S_ISSUE;
         S_ISSUE: if (w_cmd_hs)
                     w_state_nxt = (r_remaining == r_cmd_len) ? S_DRAIN : S_CALC;
         S_DRAIN: if (w_outstanding_nxt == '0) begin
                     w_done      = 1'b1;
                     w_state_nxt = S_IDLE;
                  end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge user_clk or posedge user_areset) begin
      if (user_areset) begin
         r_state       <= S_IDLE;
         r_param_ready <= 1'b0;
         r_addr        <= '0;
         r_remaining   <= '0;
         r_cmd_addr    <= '0;
         r_cmd_len     <= '0;
         r_cmds_issued <= '0;
         r_busy        <= 1'b0;
         r_outstanding <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_outstanding <= w_outstanding_nxt;
         r_param_ready <= (w_state_nxt == S_IDLE);
         if (w_param_hs) begin
            r_addr        <= bus.s_axis_param_data[63:0];
            r_remaining   <= bus.s_axis_param_data[95:64];
            r_cmds_issued <= '0;
            r_busy        <= 1'b1;
         end
         if (r_state == S_CALC) begin
            r_cmd_addr <= r_addr;
            r_cmd_len  <= w_chunk;
         end
         if (w_cmd_hs) begin
            r_addr        <= r_addr + 64'(r_cmd_len);
            r_remaining   <= r_remaining - r_cmd_len;
            r_cmds_issued <= r_cmds_issued + 32'd1;
         end
         if (w_done) r_busy <= 1'b0;
      end
   end

   assign bus.s_axis_param_ready          = r_param_ready;
   assign bus.m_axis_dma_read_cmd_valid   = w_cmd_valid;
   assign bus.m_axis_dma_read_cmd_address = r_cmd_addr;
   assign bus.m_axis_dma_read_cmd_length  = r_cmd_len;
   assign busy        = r_busy;
   assign done        = w_done;
   assign cmds_issued = r_cmds_issued;
   assign o_dbg_state = r_state;
endmodule

// File: tb/tb_hll_dma_read_splitter.sv
// Randomized scoreboard bench for hll_dma_read_splitter: a chunking model feeds
// expected commands/done counts; a negedge monitor checks everything the DUT presents.
module tb_hll_dma_read_splitter;
   localparam int MAX_CMD = 4096;
   localparam int PAGE    = 4096;
   localparam int MAX_OUT = 8;

   logic        user_clk = 1'b0;
   logic        user_areset;
   logic        busy;
   logic        done;
   logic [31:0] cmds_issued;
   logic [1:0]  dbg_state;

   hll_dma_read_splitter_if bus ();

   hll_dma_read_splitter #(
      .MAX_CMD_BYTES(MAX_CMD), .PAGE_BYTES(PAGE), .MAX_OUTSTANDING(MAX_OUT), .BEAT_BYTES(64)
   ) dut (
      .user_clk(user_clk), .user_areset(user_areset), .bus(bus),
      .busy(busy), .done(done), .cmds_issued(cmds_issued), .o_dbg_state(dbg_state)
   );

   always #5 user_clk = ~user_clk;

   int checks = 0;
   int errors = 0;
   logic [95:0] exp_cmd_q[$];
   logic [31:0] exp_done_q[$];
   int outstanding_m = 0;
   int n_cmd_hs      = 0;
   int pending_lasts = 0;
   bit auto_last  = 0;
   bit rand_ready = 0;
   bit force_last = 0;

   task automatic check_v(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      check_v(name, {95'd0, act}, {95'd0, exp});
   endtask

   task automatic fail_now(input string name, input string what);
      checks++;
      errors++;
      $display("FAIL %s: got %s expected progress at %0t", name, what, $time);
   endtask

   // Reference chunking: walk the job, cutting at MAX_CMD and at every page edge.
   function automatic void model_job(input logic [63:0] addr, input logic [31:0] len);
      logic [63:0] a = addr;
      logic [31:0] rem = len;
      logic [31:0] c;
      logic [31:0] pg;
      int n = 0;
      while (rem != 0) begin
         pg = 32'(64'(PAGE) - (a % 64'(PAGE)));
         c  = rem;
         if (c > 32'(MAX_CMD)) c = 32'(MAX_CMD);
         if (c > pg) c = pg;
         exp_cmd_q.push_back({a, c});
         a   = a + 64'(c);
         rem = rem - c;
         n++;
      end
      exp_done_q.push_back(32'(n));
   endfunction

   // Monitor / scoreboard
   logic        m_hs, m_last;
   logic        prev_valid = 0, prev_hs = 0, prev_done = 0;
   logic [95:0] prev_cmd = '0;
   always @(negedge user_clk) begin
      if (user_areset) begin
         prev_valid    = 0;
         prev_hs       = 0;
         prev_done     = 0;
         outstanding_m = 0;
      end else begin
         m_hs   = bus.m_axis_dma_read_cmd_valid && bus.m_axis_dma_read_cmd_ready;
         m_last = bus.rd_data_beat_valid && bus.rd_data_beat_ready && bus.rd_data_beat_last;
         if (bus.m_axis_dma_read_cmd_valid)
            check_b("credit_limit", outstanding_m < MAX_OUT, 1'b1);
         if (prev_valid && !prev_hs) begin
            check_b("valid_held", bus.m_axis_dma_read_cmd_valid, 1'b1);
            check_v("cmd_stable", {bus.m_axis_dma_read_cmd_address, bus.m_axis_dma_read_cmd_length}, prev_cmd);
         end
         if (prev_hs) check_b("gap_after_cmd", bus.m_axis_dma_read_cmd_valid, 1'b0);
         if (m_hs) begin
            if (exp_cmd_q.size() == 0)
               fail_now("unexpected_cmd", $sformatf("cmd %0h/%0h", bus.m_axis_dma_read_cmd_address,
                                                     bus.m_axis_dma_read_cmd_length));
            else
               check_v("cmd", {bus.m_axis_dma_read_cmd_address, bus.m_axis_dma_read_cmd_length},
                       exp_cmd_q.pop_front());
            n_cmd_hs++;
            pending_lasts++;
         end
         if (m_hs && !m_last) outstanding_m++;
         else if (!m_hs && m_last && outstanding_m > 0) outstanding_m--;
         if (prev_done) check_b("busy_fall", busy, 1'b0);
         if (done) begin
            check_b("done_all_returned", outstanding_m == 0, 1'b1);
            check_b("done_busy", busy, 1'b1);
            if (exp_done_q.size() == 0) fail_now("unexpected_done", "done pulse");
            else check_v("cmds_issued", 96'(cmds_issued), 96'(exp_done_q.pop_front()));
         end
         prev_valid = bus.m_axis_dma_read_cmd_valid;
         prev_hs    = m_hs;
         prev_done  = done;
         prev_cmd   = {bus.m_axis_dma_read_cmd_address, bus.m_axis_dma_read_cmd_length};
      end
   end

   // Read-data responder: returns one last per issued command, plus noise beats that must not count.
   initial begin
      bus.rd_data_beat_valid = 0;
      bus.rd_data_beat_ready = 0;
      bus.rd_data_beat_last  = 0;
      forever begin
         @(posedge user_clk);
         #2;
         if (force_last || (auto_last && pending_lasts > 0 && $urandom_range(0, 2) == 0)) begin
            bus.rd_data_beat_valid = 1;
            bus.rd_data_beat_ready = 1;
            bus.rd_data_beat_last  = 1;
            force_last = 0;
            if (pending_lasts > 0) pending_lasts--;
         end else begin
            bus.rd_data_beat_valid = 1'($urandom_range(0, 1));
            bus.rd_data_beat_ready = 1'($urandom_range(0, 1));
            bus.rd_data_beat_last  = (bus.rd_data_beat_valid && bus.rd_data_beat_ready) ?
                                     1'b0 : 1'($urandom_range(0, 1));
         end
      end
   end

   initial begin
      forever begin
         @(posedge user_clk);
         #1;
         if (rand_ready) bus.m_axis_dma_read_cmd_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send_job(input logic [63:0] addr, input logic [31:0] len);
      int t = 0;
      model_job(addr, len);
      @(posedge user_clk);
      #1;
      bus.s_axis_param_valid = 1;
      bus.s_axis_param_data  = {len, addr};
      @(negedge user_clk);
      while (!bus.s_axis_param_ready && t < 1000) begin
         @(negedge user_clk);
         t++;
      end
      if (t >= 1000) fail_now("param_accept_timeout", "ready low");
      @(posedge user_clk);
      #1;
      bus.s_axis_param_valid = 0;
      @(negedge user_clk);
      check_b("accept_busy", busy, 1'b1);
      check_v("accept_cmds_cleared", 96'(cmds_issued), 96'd0);
      check_b("accept_param_ready_low", bus.s_axis_param_ready, 1'b0);
      if (len == 0) check_b("zero_len_done", done, 1'b1);
      else check_b("calc_no_valid", bus.m_axis_dma_read_cmd_valid, 1'b0);
   endtask

   task automatic wait_idle(input int budget);
      int t = 0;
      @(negedge user_clk);
      while ((busy || exp_done_q.size() != 0) && t < budget) begin
         @(negedge user_clk);
         t++;
      end
      if (t >= budget) begin
         fail_now("job_timeout", "still busy");
         exp_cmd_q.delete();
         exp_done_q.delete();
      end
      check_v("cmds_consumed", 96'(exp_cmd_q.size()), 96'd0);
   endtask

   task automatic wait_cmd_count(input int n, input int budget);
      int t = 0;
      while (n_cmd_hs < n && t < budget) begin
         @(negedge user_clk);
         t++;
      end
      check_v("cmd_count_reached", 96'(n_cmd_hs), 96'(n));
   endtask

   task automatic wait_valid(input int budget);
      int t = 0;
      @(negedge user_clk);
      while (!bus.m_axis_dma_read_cmd_valid && t < budget) begin
         @(negedge user_clk);
         t++;
      end
      check_b("valid_seen", bus.m_axis_dma_read_cmd_valid, 1'b1);
   endtask

   task automatic check_all_zero(input string tag);
      check_b({tag, "_param_ready"}, bus.s_axis_param_ready, 1'b0);
      check_b({tag, "_cmd_valid"}, bus.m_axis_dma_read_cmd_valid, 1'b0);
      check_v({tag, "_cmd"}, {bus.m_axis_dma_read_cmd_address, bus.m_axis_dma_read_cmd_length}, 96'd0);
      check_b({tag, "_busy"}, busy, 1'b0);
      check_b({tag, "_done"}, done, 1'b0);
      check_v({tag, "_cmds_issued"}, 96'(cmds_issued), 96'd0);
   endtask

   initial begin
      logic [63:0] ra;
      logic [31:0] rl;
      bus.s_axis_param_valid        = 0;
      bus.s_axis_param_data         = '0;
      bus.m_axis_dma_read_cmd_ready = 0;
      user_areset = 1;
      repeat (3) @(posedge user_clk);
      @(negedge user_clk);
      check_all_zero("reset");
      @(posedge user_clk);
      #1 user_areset = 0;
      @(posedge user_clk);
      @(negedge user_clk);
      check_b("ready_after_reset", bus.s_axis_param_ready, 1'b1);

      // Aligned job, page split, zero length
      bus.m_axis_dma_read_cmd_ready = 1;
      auto_last = 1;
      send_job(64'h1000, 32'h3000);
      wait_idle(2000);
      send_job(64'h0F80, 32'h100);
      wait_idle(2000);
      send_job(64'h5000, 32'h0);
      wait_idle(50);

      // Credit throttle with no lasts returned
      auto_last = 0;
      n_cmd_hs  = 0;
      send_job(64'h0, 32'h10000);
      repeat (60) @(negedge user_clk);
      check_v("throttle_count", 96'(n_cmd_hs), 96'd8);
      check_b("throttle_valid_low", bus.m_axis_dma_read_cmd_valid, 1'b0);
      @(posedge user_clk);
      #1 force_last = 1;
      wait_cmd_count(9, 20);
      @(posedge user_clk);
      #1 bus.m_axis_dma_read_cmd_ready = 0;
      @(posedge user_clk);
      #1 force_last = 1;
      wait_valid(20);
      @(posedge user_clk);
      #1;
      bus.m_axis_dma_read_cmd_ready = 1;
      force_last = 1;
      @(posedge user_clk);
      @(posedge user_clk);
      @(negedge user_clk);
      check_b("simul_inc_dec_credit", bus.m_axis_dma_read_cmd_valid, 1'b1);
      auto_last  = 1;
      rand_ready = 1;
      wait_idle(4000);
      rand_ready = 0;

      // Backpressure on first command
      @(posedge user_clk);
      #1 bus.m_axis_dma_read_cmd_ready = 0;
      send_job(64'h40, 32'h2000);
      wait_valid(20);
      repeat (20) @(negedge user_clk);
      check_v("bp_cmd", {bus.m_axis_dma_read_cmd_address, bus.m_axis_dma_read_cmd_length},
              {64'h40, 32'hFC0});
      @(posedge user_clk);
      #1 bus.m_axis_dma_read_cmd_ready = 1;
      wait_idle(2000);

      // Address wrap past 2^64-1
      send_job(64'hFFFF_FFFF_FFFF_F800, 32'h1000);
      wait_idle(2000);

      // Random jobs
      rand_ready = 1;
      for (int i = 0; i < 20; i++) begin
         ra = {$urandom(), $urandom()};
         rl = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 32'h3000));
         send_job(ra, rl);
         wait_idle(4000);
      end
      rand_ready = 0;

      // Reset while the second command is pending
      @(posedge user_clk);
      #1 bus.m_axis_dma_read_cmd_ready = 1;
      auto_last = 0;
      n_cmd_hs  = 0;
      send_job(64'h0, 32'h4000);
      wait_cmd_count(1, 50);
      @(posedge user_clk);
      #1 bus.m_axis_dma_read_cmd_ready = 0;
      wait_valid(20);
      user_areset = 1;
      #1;
      check_all_zero("midjob_reset");
      exp_cmd_q.delete();
      exp_done_q.delete();
      pending_lasts = 0;
      force_last    = 0;
      repeat (2) @(posedge user_clk);
      #1 user_areset = 0;
      @(posedge user_clk);
      @(negedge user_clk);
      check_b("ready_after_midjob_reset", bus.s_axis_param_ready, 1'b1);
      auto_last = 1;
      bus.m_axis_dma_read_cmd_ready = 1;
      send_job(64'h100, 32'h80);
      wait_idle(2000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
